regfile_write_ctrl: RTL and testbench

//  Owns the single write port (we3/a3/wd3) of the 32x32 MIPS register file.

---
 rtl/regfile_write_ctrl_pkg.sv | 7 +
 rtl/regfile_write_ctrl_if.sv | 25 ++
 rtl/regfile_write_ctrl_rr_arbiter.sv | 50 +++++
 rtl/regfile_write_ctrl.sv | 105 ++++++++++
 tb/tb_regfile_write_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_ctrl_pkg.sv
// Shared widths and constants for the register-file write-port controller.
package rf_ctrl_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Writeback request bus between the NREQ writeback sources and the write-port controller.
interface regfile_write_ctrl_if
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0] req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input req_ready
    );

    modport slave (
        input req_valid,
        input req_addr,
        input req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping modulo NREQ.
// The pointer moves past the winner only when the advance strobe is asserted.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input logic clk,
    input logic rst_n,
    input logic [NREQ-1:0] req,
    input logic advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx;
    logic found;
    int j;

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        idx = '0;
        j = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = IDX_W'(j);
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (int'(gnt_idx) == NREQ - 1) ptr_d = '0;
            else ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// Owns the register-file write port: arbitrates writeback sources onto we3/a3/wd3
// and keeps a per-register pending scoreboard for RAW hazard detection.
module regfile_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input logic clk,
    input logic rst_n,
    regfile_write_ctrl_if.slave wb,
    output logic rf_we3,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    input logic rsv_valid,
    input logic [ADDR_W-1:0] rsv_addr,
    output logic rsv_ready,
    input logic [ADDR_W-1:0] chk_a1,
    input logic [ADDR_W-1:0] chk_a2,
    output logic hazard1,
    output logic hazard2,
    output logic [NREGS-1:0] pending
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic rf_we3_q, rf_we3_d;
    logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
    logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
    logic [NREGS-1:0] pending_q, pending_d;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .req(wb.req_valid),
        .advance(accept),
        .gnt(gnt),
        .gnt_idx(gnt_idx)
    );

    // gnt is only ever raised on a valid requester, so any grant is an accept.
    assign wb.req_ready = gnt;
    assign accept = |gnt;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_addr = wb.req_addr[i*ADDR_W +: ADDR_W];
                win_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rf_we3_d = 1'b0;
        rf_a3_d = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        if (accept) begin
            rf_we3_d = (win_addr != REG_ZERO);
            rf_a3_d = win_addr;
            rf_wd3_d = win_data;
        end
    end

    assign rsv_ready = (rsv_addr == REG_ZERO) | ~pending_q[rsv_addr];

    // Clear first so a reservation landing on the commit edge of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (rf_we3_q) pending_d[rf_a3_q] = 1'b0;
        if (rsv_valid && rsv_ready && (rsv_addr != REG_ZERO)) pending_d[rsv_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we3_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd3_q <= '0;
            pending_q <= '0;
        end else begin
            rf_we3_q <= rf_we3_d;
            rf_a3_q <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            pending_q <= pending_d;
        end
    end

    assign hazard1 = (chk_a1 != REG_ZERO) & pending_q[chk_a1];
    assign hazard2 = (chk_a2 != REG_ZERO) & pending_q[chk_a2];

    assign rf_we3 = rf_we3_q;
    assign rf_a3 = rf_a3_q;
    assign rf_wd3 = rf_wd3_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl with NREQ=2: arbitration, $0 writes,
// scoreboard reserve/clear, set-wins collision and asynchronous reset.
module tb_regfile_write_ctrl;
    import rf_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic rf_we3;
    logic [ADDR_W-1:0] rf_a3;
    logic [DATA_W-1:0] rf_wd3;
    logic rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic rsv_ready;
    logic [ADDR_W-1:0] chk_a1;
    logic [ADDR_W-1:0] chk_a2;
    logic hazard1;
    logic hazard2;
    logic [NREGS-1:0] pending;

    int checks;
    int errors;

    regfile_write_ctrl_if #(.NREQ(2)) wb ();

    regfile_write_ctrl #(.NREQ(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb(wb.slave),
        .rf_we3(rf_we3),
        .rf_a3(rf_a3),
        .rf_wd3(rf_wd3),
        .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr),
        .rsv_ready(rsv_ready),
        .chk_a1(chk_a1),
        .chk_a2(chk_a2),
        .hazard1(hazard1),
        .hazard2(hazard2),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        wb.req_valid = v;
        wb.req_addr = {a1, a0};
        wb.req_data = {d1, d0};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wb.req_valid = '0;
        wb.req_addr = '0;
        wb.req_data = '0;
        rsv_valid = 1'b0;
        rsv_addr = '0;
        chk_a1 = '0;
        chk_a2 = '0;
        #2;
        checks++;
        if (rf_we3 !== 1'b0 || rf_a3 !== 5'd0 || rf_wd3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got we3=%b a3=%0d wd3=%h exp 0/0/0", rf_we3, rf_a3, rf_wd3);
        end
        checks++;
        if (pending !== 32'd0 || wb.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got pending=%h ready=%b exp 0/00", pending, wb.req_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        checks++;
        if (wb.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b exp 01", wb.req_ready);
        end
        tick();
        checks++;
        if (rf_we3 !== 1'b1 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write got we3=%b a3=%0d wd3=%h exp 1/5/deadbeef", rf_we3, rf_a3, rf_wd3);
        end
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        checks++;
        if (rf_we3 !== 1'b0 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_hold got we3=%b a3=%0d wd3=%h exp 0/5/deadbeef", rf_we3, rf_a3, rf_wd3);
        end
        checks++;
        if (pending !== 32'd0) begin
            errors++;
            $display("FAIL unreserved_clear got pending=%h exp 0", pending);
        end
    endtask

    // Pointer is 1 after the single write, so requester 1 goes first.
    task automatic test_round_robin();
        logic [1:0] exp_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [4:0] exp_addr [4] = '{5'd11, 5'd10, 5'd11, 5'd10};
        set_req(2'b11, 5'd10, 32'hAAAA0000, 5'd11, 32'hBBBB1111);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wb.req_ready !== exp_gnt[k]) begin
                errors++;
                $display("FAIL rr_grant[%0d] got %b exp %b", k, wb.req_ready, exp_gnt[k]);
            end
            tick();
            checks++;
            if (rf_we3 !== 1'b1 || rf_a3 !== exp_addr[k]) begin
                errors++;
                $display("FAIL rr_write[%0d] got we3=%b a3=%0d exp 1/%0d", k, rf_we3, rf_a3, exp_addr[k]);
            end
        end
        set_req(2'b01, 5'd12, 32'hCCCC2222, 5'd11, 32'hBBBB1111);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (wb.req_ready !== 2'b01) begin
                errors++;
                $display("FAIL solo_grant[%0d] got %b exp 01", k, wb.req_ready);
            end
            tick();
        end
        checks++;
        if (rf_a3 !== 5'd12 || rf_wd3 !== 32'hCCCC2222) begin
            errors++;
            $display("FAIL solo_write got a3=%0d wd3=%h exp 12/cccc2222", rf_a3, rf_wd3);
        end
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
    endtask

    // Pointer is 1 here; a $0 write must still consume the grant.
    task automatic test_zero_write();
        set_req(2'b10, 5'd3, 32'd0, 5'd0, 32'h1234);
        checks++;
        if (wb.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL zero_ready got %b exp 10", wb.req_ready);
        end
        tick();
        checks++;
        if (rf_we3 !== 1'b0 || rf_a3 !== 5'd0 || rf_wd3 !== 32'h1234) begin
            errors++;
            $display("FAIL zero_write got we3=%b a3=%0d wd3=%h exp 0/0/1234", rf_we3, rf_a3, rf_wd3);
        end
        set_req(2'b11, 5'd3, 32'd0, 5'd0, 32'h1234);
        checks++;
        if (wb.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL zero_ptr_adv got %b exp 01", wb.req_ready);
        end
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic test_scoreboard();
        chk_a1 = 5'd7;
        chk_a2 = 5'd7;
        rsv_addr = 5'd0;
        rsv_valid = 1'b1;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_zero_ready got %b exp 1", rsv_ready);
        end
        tick();
        checks++;
        if (pending !== 32'd0) begin
            errors++;
            $display("FAIL rsv_zero_noop got pending=%h exp 0", pending);
        end
        rsv_addr = 5'd7;
        #1;
        checks++;
        if (rsv_ready !== 1'b1 || hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL rsv7_pre got ready=%b hz1=%b exp 1/0", rsv_ready, hazard1);
        end
        tick();
        checks++;
        if (pending !== 32'h0000_0080 || hazard1 !== 1'b1 || hazard2 !== 1'b1) begin
            errors++;
            $display("FAIL rsv7_set got pending=%h hz1=%b hz2=%b exp 80/1/1", pending, hazard1, hazard2);
        end
        checks++;
        if (rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsv7_second got ready=%b exp 0", rsv_ready);
        end
        rsv_valid = 1'b0;
        chk_a2 = 5'd0;
        set_req(2'b01, 5'd7, 32'h0000_0077, 5'd0, 32'd0);
        checks++;
        if (hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_r0 got %b exp 0", hazard2);
        end
        tick();
        checks++;
        if (rf_we3 !== 1'b1 || rf_a3 !== 5'd7 || pending[7] !== 1'b1 || hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL w7_commit got we3=%b a3=%0d p7=%b hz1=%b exp 1/7/1/1", rf_we3, rf_a3, pending[7], hazard1);
        end
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        checks++;
        if (pending !== 32'd0 || hazard1 !== 1'b0 || rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL w7_clear got pending=%h hz1=%b ready=%b exp 0/0/1", pending, hazard1, rsv_ready);
        end
    endtask

    task automatic test_simultaneous();
        set_req(2'b01, 5'd9, 32'h0000_0099, 5'd0, 32'd0);
        tick();
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++;
        if (rf_we3 !== 1'b1 || rf_a3 !== 5'd9) begin
            errors++;
            $display("FAIL w9_drive got we3=%b a3=%0d exp 1/9", rf_we3, rf_a3);
        end
        rsv_addr = 5'd9;
        rsv_valid = 1'b1;
        #1;
        tick();
        rsv_valid = 1'b0;
        checks++;
        if (pending !== 32'h0000_0200) begin
            errors++;
            $display("FAIL set_wins got pending=%h exp 200", pending);
        end
    endtask

    task automatic test_reset_mid();
        rsv_addr = 5'd3;
        rsv_valid = 1'b1;
        #1;
        tick();
        rsv_valid = 1'b0;
        set_req(2'b01, 5'd3, 32'h0000_0033, 5'd0, 32'd0);
        tick();
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        checks++;
        if (rf_we3 !== 1'b1 || pending !== 32'h0000_0208) begin
            errors++;
            $display("FAIL pre_reset got we3=%b pending=%h exp 1/208", rf_we3, pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we3 !== 1'b0 || pending !== 32'd0 || rf_a3 !== 5'd0 || rf_wd3 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got we3=%b pending=%h a3=%0d wd3=%h exp 0/0/0/0", rf_we3, pending, rf_a3, rf_wd3);
        end
        tick();
        checks++;
        if (rf_we3 !== 1'b0 || pending !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold got we3=%b pending=%h exp 0/0", rf_we3, pending);
        end
        #2;
        rst_n = 1'b1;
        set_req(2'b11, 5'd1, 32'd1, 5'd2, 32'd2);
        checks++;
        if (wb.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL ptr_reset got %b exp 01", wb.req_ready);
        end
        set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_write();
        test_scoreboard();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
